// File: rtl/bitminer_pkg.sv
// Shared definitions for the mining datapath: frame constants, result payload
// layout and the UART transmit state encoding.
package bitminer_pkg;

  localparam logic [7:0]  FRAME_SYNC  = 8'hA5;
  localparam int unsigned FRAME_BYTES = 38;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned DIGEST_W    = 8 * WORD_W;

  // Captured result; nonce sits on top so it leaves first when shifted out MSB-first.
  typedef struct packed {
    logic [WORD_W-1:0]   nonce;
    logic [DIGEST_W-1:0] digest;
  } result_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter. A load while ready starts a byte; ready is high when
// idle and during the final cycle of a stop bit, so bytes chain with no gap.
module uart_tx_byte
  import bitminer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             ready_n, tx_n;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ready   <= 1'b1;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      ready   <= ready_n;
      tx      <= tx_n;
    end
  end

  // tx follows the current state one cycle late, so every bit on the line
  // spans exactly one state dwell.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = 1'b1;

    if (state != IDLE) begin
      cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (load) begin
          state_n   = START;
          shreg_n   = data;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[bit_idx];
        if (bit_end) begin
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (load) begin
            state_n = START;
            shreg_n = data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    ready_n = (state_n == IDLE) || ((state_n == STOP) && (cnt_n == CNT_LAST));
  end

endmodule

// File: rtl/hash_reporter.sv
// Captures a finished digest with its nonce and streams it to the host as a
// framed, XOR-checksummed 8N1 byte sequence; strobes seen while busy are counted.
module hash_reporter
  import bitminer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        digest_valid,
  input  logic [31:0] nonce,
  input  logic [31:0] h1,
  input  logic [31:0] h2,
  input  logic [31:0] h3,
  input  logic [31:0] h4,
  input  logic [31:0] h5,
  input  logic [31:0] h6,
  input  logic [31:0] h7,
  input  logic [31:0] h8,
  output logic        tx_out,
  output logic        busy,
  output logic [7:0]  dropped_count
);

  localparam int unsigned      IDX_W    = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] CSUM_PRE = IDX_W'(FRAME_BYTES - 2);

  result_t          shadow;
  logic [7:0]       checksum;
  logic [IDX_W-1:0] byte_idx;
  logic             tx_ready;
  logic             capture_c, advance_c, finish_c, load_c;
  logic [7:0]       byte_c;

  assign capture_c = digest_valid && !busy;
  assign advance_c = busy && tx_ready && (byte_idx != LAST_IDX);
  assign finish_c  = busy && tx_ready && (byte_idx == LAST_IDX);
  assign load_c    = capture_c || advance_c;

  // Next byte for the transmitter: sync on capture, checksum last, else payload.
  always_comb begin
    byte_c = shadow.nonce[31:24];
    if (capture_c) begin
      byte_c = FRAME_SYNC;
    end else if (byte_idx == CSUM_PRE) begin
      byte_c = checksum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      checksum <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
    end else if (capture_c) begin
      shadow   <= result_t'({nonce, h1, h2, h3, h4, h5, h6, h7, h8});
      checksum <= '0;
      byte_idx <= '0;
      busy     <= 1'b1;
    end else if (advance_c) begin
      byte_idx <= byte_idx + IDX_W'(1);
      if (byte_idx != CSUM_PRE) begin
        checksum <= checksum ^ shadow.nonce[31:24];
        shadow   <= result_t'(shadow << 8);
      end
    end else if (finish_c) begin
      byte_idx <= '0;
      busy     <= 1'b0;
    end
  end

  // Saturating count of strobes that arrive while a frame is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_count <= '0;
    end else if (digest_valid && busy && (dropped_count != 8'hFF)) begin
      dropped_count <= dropped_count + 8'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load_c),
    .data (byte_c),
    .ready(tx_ready),
    .tx   (tx_out)
  );

endmodule
